// File: rtl/prog_mem_loader.sv
// prog_mem_loader: writes a framed byte-stream program image into the byte-wide
// program memory. The CPU is held in reset until a complete image is loaded.
// Frame: SYNC_BYTE, LEN (0 means 256), LEN data bytes[, checksum byte].
// Optional checksum trailer and error state: define PROG_LOADER_CHECKSUM_EN.
module prog_mem_loader #(
  parameter int unsigned          ADD_WIDTH = 8,
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     SYNC_BYTE = WIDTH'(8'hA5),
  parameter logic [ADD_WIDTH-1:0] BASE_ADDR = ADD_WIDTH'(8'h00)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mem_wen,
  output logic [ADD_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 cpu_rst_n,
  output logic                 done,
  output logic                 error
);

  // One extra bit so a length byte of zero can stand for a full 256-byte image.
  localparam int unsigned CNT_W = WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    LEN  = 3'd2,
    LOAD = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
    CHK  = 3'd4,
    ERR  = 3'd6,
`endif
    DONE = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       remaining_q, remaining_d;
  logic [ADD_WIDTH-1:0]   offset_q, offset_d;
  logic                   mem_wen_q, mem_wen_d;
  logic [ADD_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
  logic                   done_q, done_d;
  logic                   cpu_rst_n_q, cpu_rst_n_d;
  logic                   accept;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0]       sum_q, sum_d;
  logic                   error_q, error_d;
`endif

  // Ready is a pure decode of the current state.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      SYNC, LEN, LOAD: in_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK:             in_ready = 1'b1;
`endif
      default:         in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Frame parser: next state, byte counters and the registered write port.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    offset_d    = offset_q;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      IDLE: state_d = SYNC;
      SYNC: begin
        if (accept && (in_data == SYNC_BYTE)) state_d = LEN;
      end
      LEN: begin
        if (accept) begin
          remaining_d = (in_data == '0) ? {1'b1, {WIDTH{1'b0}}} : CNT_W'(in_data);
          offset_d    = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d       = '0;
`endif
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          mem_wen_d   = 1'b1;
          mem_addr_d  = BASE_ADDR + offset_q;
          mem_wdata_d = in_data;
          offset_d    = offset_q + ADD_WIDTH'(1);
          remaining_d = remaining_q - CNT_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d       = sum_q + in_data;
          if (remaining_q == CNT_W'(1)) state_d = CHK;
`else
          if (remaining_q == CNT_W'(1)) state_d = DONE;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) state_d = (in_data == sum_q) ? DONE : ERR;
      end
      ERR: begin
        if (load_start) state_d = SYNC;
      end
`endif
      DONE: begin
        if (load_start) state_d = SYNC;
      end
      default: state_d = IDLE;
    endcase
    // Status outputs track the state being entered, so they settle with it.
    done_d      = (state_d == DONE);
    cpu_rst_n_d = (state_d == DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
    error_d     = (state_d == ERR);
`endif
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      offset_q    <= '0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      cpu_rst_n_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      offset_q    <= offset_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      cpu_rst_n_q <= cpu_rst_n_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      error_q     <= error_d;
`endif
    end
  end

  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign cpu_rst_n = cpu_rst_n_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign error     = error_q;
`else
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: randomized frame stimulus checked every cycle against a
// byte-level frame parser model, plus literal checks for the directed frames.
module tb_prog_mem_loader;

  localparam logic [7:0] BASE   = 8'h10;
  localparam logic [7:0] SYNC_B = 8'hA5;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  // Model phases (byte-parser view of the frame, not a copy of the DUT).
  localparam int P_BOOT = 0, P_HUNT = 1, P_LEN = 2, P_DATA = 3, P_CHK = 4, P_OK = 5, P_BAD = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, mem_wen, cpu_rst_n, done, error;
  logic [7:0] mem_addr, mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  int         phase = P_BOOT;
  int         need  = 0;
  logic [7:0] msum  = 8'h00;
  logic [7:0] moff  = 8'h00;
  bit         exp_wen = 1'b0;
  logic [7:0] exp_addr = 8'h00, exp_wdata = 8'h00;

  logic [7:0] log_addr[$];
  logic [7:0] log_data[$];

  prog_mem_loader #(
    .ADD_WIDTH(8), .WIDTH(8), .SYNC_BYTE(SYNC_B), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model each cycle, then advance the model by the
  // beat (if any) that the next rising edge will accept.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        phase   = P_BOOT;
        exp_wen = 1'b0;
        check("rst_mem_wen",   32'(mem_wen),   32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_error",     32'(error),     32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
      end else begin
        check("mem_wen", 32'(mem_wen), 32'(exp_wen));
        if (mem_wen === 1'b1) begin
          log_addr.push_back(mem_addr);
          log_data.push_back(mem_wdata);
        end
        if (exp_wen) begin
          check("mem_addr",  32'(mem_addr),  32'(exp_addr));
          check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        end
        check("done",      32'(done),      32'(phase == P_OK));
        check("error",     32'(error),     32'(phase == P_BAD));
        check("cpu_rst_n", 32'(cpu_rst_n), 32'(phase == P_OK));
        check("in_ready",  32'(in_ready),  32'(phase >= P_HUNT && phase <= P_CHK));
        exp_wen = 1'b0;
        if (phase == P_BOOT) begin
          phase = P_HUNT;
        end else if (phase == P_OK || phase == P_BAD) begin
          if (load_start) phase = P_HUNT;
        end else if (in_valid) begin
          case (phase)
            P_HUNT: if (in_data == SYNC_B) phase = P_LEN;
            P_LEN: begin
              need  = (in_data == 8'h00) ? 256 : int'(in_data);
              msum  = 8'h00;
              moff  = 8'h00;
              phase = P_DATA;
            end
            P_DATA: begin
              exp_wen   = 1'b1;
              exp_addr  = BASE + moff;
              exp_wdata = in_data;
              moff      = moff + 8'd1;
              msum      = msum + in_data;
              need      = need - 1;
              if (need == 0) phase = CK ? P_CHK : P_OK;
            end
            P_CHK: phase = (in_data == msum) ? P_OK : P_BAD;
            default: phase = P_HUNT;
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Offer one byte, optionally after a short bubble; bounded wait for acceptance.
  task automatic send_byte(input logic [7:0] b, input bit bubbles);
    bit acc = 1'b0;
    int n   = 0;
    if (bubbles) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat ($urandom_range(0, 2)) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: byte %h not accepted within 64 cycles", b);
    end
  endtask

  task automatic send_frame(input logic [7:0] data[$], input bit good, input bit bubbles);
    logic [7:0] s = 8'h00;
    logic [7:0] chk;
    send_byte(SYNC_B, bubbles);
    send_byte(8'(data.size()), bubbles);
    foreach (data[i]) begin
      send_byte(data[i], bubbles);
      s = s + data[i];
    end
    chk = good ? s : s + 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(chk, bubbles);
`endif
    $display("[TB] frame len=%0d chk=%h", data.size(), chk);
  endtask

  initial begin
    logic [7:0] d[$];
    int mark;
    rst = 1'b0;
    repeat (3) tick();
    check("reset_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("reset_mem_addr",  32'(mem_addr),  32'd0);
    rst = 1'b1;

    // Basic frame.
    d = '{8'h13, 8'h05, 8'h00, 8'h00};
    mark = log_addr.size();
    send_frame(d, 1'b1, 1'b0);
    check("A_done_latency",  32'(done),      32'd1);
    check("A_cpu_rst_n",     32'(cpu_rst_n), 32'd1);
    repeat (2) tick();
    check("A_nwrites", 32'(log_addr.size() - mark), 32'd4);
    check("A_w0", 32'({log_addr[mark],   log_data[mark]}),   32'h1013);
    check("A_w1", 32'({log_addr[mark+1], log_data[mark+1]}), 32'h1105);
    check("A_w2", 32'({log_addr[mark+2], log_data[mark+2]}), 32'h1200);
    check("A_w3", 32'({log_addr[mark+3], log_data[mark+3]}), 32'h1300);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Bad checksum, then recovery.
    pulse_load();
    mark = log_addr.size();
    send_frame(d, 1'b0, 1'b0);
    repeat (2) tick();
    check("B_error",     32'(error),     32'd1);
    check("B_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("B_nwrites",   32'(log_addr.size() - mark), 32'd4);
    pulse_load();
    check("B_error_clear", 32'(error), 32'd0);
    send_frame(d, 1'b1, 1'b0);
    check("B_done", 32'(done), 32'd1);
`endif

    // Noise before sync.
    pulse_load();
    check("C_done_clear", 32'(done), 32'd0);
    mark = log_addr.size();
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h5A, 1'b0);
    d = '{8'h7F};
    send_frame(d, 1'b1, 1'b0);
    repeat (2) tick();
    check("C_nwrites", 32'(log_addr.size() - mark), 32'd1);
    check("C_w0", 32'({log_addr[mark], log_data[mark]}), 32'h107F);
    check("C_done", 32'(done), 32'd1);

    // Bubbles on a 4-byte frame.
    pulse_load();
    d = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    mark = log_addr.size();
    send_frame(d, 1'b1, 1'b1);
    repeat (2) tick();
    check("D_nwrites", 32'(log_addr.size() - mark), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("D_addr", 32'(log_addr[mark+i]), 32'(BASE + 8'(i)));
      check("D_data", 32'(log_data[mark+i]), 32'(d[i]));
    end

    // Full 256-byte image wraps the address space.
    pulse_load();
    d = {};
    for (int i = 0; i < 256; i++) d.push_back(8'(i));
    mark = log_addr.size();
    send_frame(d, 1'b1, 1'b0);
    repeat (2) tick();
    check("E_nwrites", 32'(log_addr.size() - mark), 32'd256);
    check("E_first", 32'({log_addr[mark],     log_data[mark]}),     32'h1000);
    check("E_last",  32'({log_addr[mark+255], log_data[mark+255]}), 32'h0FFF);
    check("E_done", 32'(done), 32'd1);

    // Reset after the second data byte.
    pulse_load();
    send_byte(SYNC_B, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst = 1'b0;
    #1;
    check("F_async_wen",   32'(mem_wen),   32'd0);
    check("F_async_addr",  32'(mem_addr),  32'd0);
    check("F_async_wdata", 32'(mem_wdata), 32'd0);
    check("F_async_ready", 32'(in_ready),  32'd0);
    repeat (2) tick();
    rst = 1'b1;
    d = '{8'h31, 8'h32, 8'h33};
    mark = log_addr.size();
    send_frame(d, 1'b1, 1'b0);
    repeat (2) tick();
    check("F_nwrites", 32'(log_addr.size() - mark), 32'd3);
    check("F_w0", 32'({log_addr[mark], log_data[mark]}), 32'h1031);
    check("F_done", 32'(done), 32'd1);

    // Randomized frames, noise, ignored load_start and checksum errors.
    for (int it = 0; it < 25; it++) begin
      pulse_load();
      if ($urandom_range(0, 1) == 1) pulse_load();
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] nb;
        nb = 8'($urandom);
        if (nb == SYNC_B) nb = 8'h00;
        send_byte(nb, 1'b1);
      end
      d = {};
      repeat ($urandom_range(1, 40)) d.push_back(8'($urandom));
      send_frame(d, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      repeat (2) tick();
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Byte-stream loader that writes a program image into the byte-wide instruction memory the CPU fetches from. This block is the writer side of the program memory port; the CPU fetch path is the reader.
- Holds the CPU core in reset while an image is being loaded, then releases it when the image is complete and valid.
- Sits between a host byte source (UART/SPI front end, valid/ready) and the program memory write port.

Parameters:
- ADD_WIDTH, 8, program memory address width (256 bytes deep).
- WIDTH, 8, data byte width.
- SYNC_BYTE, 8'hA5, frame start marker.
- BASE_ADDR, 8'h00, address where the first data byte is written.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_start  input  1  one-cycle pulse; re-arms the loader from DONE or ERR.
- in_data  input  WIDTH  incoming byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_wen  output  1  program memory write enable.
- mem_addr  output  ADD_WIDTH  program memory write address.
- mem_wdata  output  WIDTH  program memory write data.
- cpu_rst_n  output  1  active-low reset to the CPU core; low while loading.
- done  output  1  image loaded and accepted.
- error  output  1  checksum failure.

Behaviour:
- Handshake: a beat is accepted when in_valid & in_ready on a rising clk edge. in_ready is combinational from the state: 1 in SYNC, LEN, LOAD and CHK; 0 otherwise. in_valid may drop at any time (bubbles allowed).
- States: IDLE, SYNC, LEN, LOAD, CHK, DONE, ERR.
- IDLE -> SYNC: unconditionally, one cycle after reset release.
- SYNC: an accepted byte equal to SYNC_BYTE -> LEN. Any other byte is discarded and the state stays SYNC.
- LEN: accepted byte N sets remaining = N, with N=0 meaning 256 (9-bit counter). Clear running sum and offset. -> LOAD.
- LOAD: each accepted byte is summed mod 256.
  - Next cycle: mem_wen=1 for exactly one cycle, mem_addr = (BASE_ADDR + offset) mod 2^ADD_WIDTH (wrap-around), mem_wdata = byte.
  - offset increments and remaining decrements.
  - On the last byte -> CHK (with checksum feature) or DONE (without).
- CHK: accepted byte == sum -> DONE; otherwise -> ERR.
- DONE: done=1, cpu_rst_n=1.
- ERR: error=1, cpu_rst_n=0.
- load_start while in DONE or ERR -> SYNC: done, error and cpu_rst_n clear the next cycle. load_start in any other state is ignored.
- Outputs are registered: done, error, cpu_rst_n, mem_wen, mem_addr, mem_wdata.
- Reset values: all outputs 0 (cpu_rst_n=0, mem_addr=0, mem_wdata=0); state IDLE.
- Reset mid-frame: the frame is abandoned and the loader restarts at IDLE. Bytes already written stay in memory.
- Latency: write occurs 1 cycle after byte acceptance. cpu_rst_n rises 1 cycle after the final accepted byte (checksum byte, or last data byte without the checksum feature).

Optional Feature:
- PROG_LOADER_CHECKSUM_EN
  - Defined: frame = SYNC, LEN, N data bytes, CHK byte (8-bit sum of the data bytes); a mismatch goes to ERR.
  - Undefined: no CHK byte and no CHK state; the last data byte -> DONE; error is tied 0 and ERR is unreachable.

Test Plan:
- Checksum on, BASE_ADDR=0: stream A5 04 13 05 00 00 18 -> writes 0x13@0, 0x05@1, 0x00@2, 0x00@3; done=1, cpu_rst_n=1 one cycle after 0x18 is accepted.
- Same frame with CHK=0x19 -> four writes occur, error=1, cpu_rst_n stays 0. Then load_start pulse plus a correct frame -> error=0, done=1.
- Noise before sync: 00 FF 5A A5 01 7F 7F -> single write 0x7F@0, done=1. The noise bytes cause no writes.
- BASE_ADDR=8'h10, LEN=00 (256 bytes, value = index) -> last write at mem_addr=0x0F (wrap); checksum 0x80 accepted.
- Backpressure/bubbles: in_valid toggling 1-0-1 across a 4-byte frame -> writes only on accepted beats, addresses contiguous 0..3, no duplicates.
- rst asserted after the 2nd data byte -> outputs zero asynchronously, state IDLE. A new full frame loads correctly from BASE_ADDR.
